// File: rtl/divide_fp.sv
// Iterative sign-magnitude fixed-point divider (16.8 default), one quotient bit per clock.
// Define DIVIDE_FP_ROUND_EN for round-half-up; otherwise the quotient truncates toward zero.
module divide_fp #(
  parameter int SIZE     = 24,
  parameter int INT_SIZE = 16,
  parameter int DEC_SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] out,
  output logic            div_zero,
  output logic            overflow
);

  localparam int MAG_W = SIZE - 1;
  localparam int QBITS = MAG_W + DEC_SIZE;
  localparam int CNT_W = $clog2(QBITS);

  if (SIZE != INT_SIZE + DEC_SIZE) begin : g_bad_cfg
    $error("divide_fp: SIZE must equal INT_SIZE + DEC_SIZE");
  end

  typedef enum logic [1:0] {IDLE, RUN, ROUND} state_t;

  state_t             state_q, state_d;
  logic [QBITS-1:0]   num_q, num_d;
  logic [QBITS-1:0]   quo_q, quo_d;
  logic [SIZE-1:0]    rem_q, rem_d;
  logic [MAG_W-1:0]   den_q, den_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SIZE-1:0]    out_q, out_d;
  logic               div_zero_q, div_zero_d;
  logic               overflow_q, overflow_d;

  logic [SIZE-1:0]    rem_shift;
  logic               round_up;
  logic [QBITS:0]     quo_rnd;
  logic               sat;
  logic [MAG_W-1:0]   mag;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      den_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_q      <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      den_q      <= den_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      out_q      <= out_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(QBITS - 1)) state_d = ROUND;
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The remainder stays below den, so dropping its MSB in the shift loses nothing.
  assign rem_shift = {rem_q[SIZE-2:0], num_q[QBITS-1]};

`ifdef DIVIDE_FP_ROUND_EN
  assign round_up = ({rem_q, 1'b0} >= {2'b00, den_q});
`else
  assign round_up = 1'b0;
`endif

  assign quo_rnd = {1'b0, quo_q} + (QBITS+1)'(round_up);
  assign sat     = |quo_rnd[QBITS:MAG_W];
  assign mag     = sat ? {MAG_W{1'b1}} : quo_rnd[MAG_W-1:0];

  // NOTE: every target gets a default first so no path through the case infers a latch.
  always_comb begin
    num_d      = num_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    den_d      = den_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    out_d      = out_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d  = {a[MAG_W-1:0], {DEC_SIZE{1'b0}}};
          den_d  = b[MAG_W-1:0];
          sign_d = a[SIZE-1] ^ b[SIZE-1];
          quo_d  = '0;
          rem_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
        end
      end
      RUN: begin
        num_d = num_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (rem_shift >= {1'b0, den_q}) begin
          rem_d = rem_shift - {1'b0, den_q};
          quo_d = {quo_q[QBITS-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[QBITS-2:0], 1'b0};
        end
      end
      ROUND: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (den_q == '0) begin
          out_d      = {sign_q, {MAG_W{1'b1}}};
          div_zero_d = 1'b1;
          overflow_d = 1'b0;
        end else begin
          // A zero magnitude is always reported as +0.
          out_d      = (mag == '0) ? '0 : {sign_q, mag};
          div_zero_d = 1'b0;
          overflow_d = sat;
        end
      end
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out      = out_q;
  assign div_zero = div_zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_divide_fp.sv
// Self-checking bench for divide_fp: directed vector table plus handshake/reset sequences.
module tb_divide_fp;

  localparam int SIZE = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [SIZE-1:0] a, b;
  logic            busy, done, div_zero, overflow;
  logic [SIZE-1:0] out;

  int checks = 0;
  int errors = 0;

  divide_fp #(.SIZE(SIZE), .INT_SIZE(16), .DEC_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] exp_out;
    logic            exp_dz;
    logic            exp_ov;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands and hold start through one edge (the accept edge).
  task automatic start_op(input logic [SIZE-1:0] aa, input logic [SIZE-1:0] bb);
    a = aa;
    b = bb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded so a stuck design still terminates.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
    end
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  initial begin
    int edges, pulses;

    vecs[0] = '{24'h000600, 24'h000200, 24'h000300, 1'b0, 1'b0};
    vecs[1] = '{24'h800100, 24'h000300, 24'h800055, 1'b0, 1'b0};
`ifdef DIVIDE_FP_ROUND_EN
    vecs[2] = '{24'h000200, 24'h000300, 24'h0000AB, 1'b0, 1'b0};
`else
    vecs[2] = '{24'h000200, 24'h000300, 24'h0000AA, 1'b0, 1'b0};
`endif
    vecs[3] = '{24'h800500, 24'h000000, 24'hFFFFFF, 1'b1, 1'b0};
    vecs[4] = '{24'h800500, 24'h800000, 24'h7FFFFF, 1'b1, 1'b0};
    vecs[5] = '{24'h7FFFFF, 24'h000001, 24'h7FFFFF, 1'b0, 1'b1};
    vecs[6] = '{24'h800000, 24'h800100, 24'h000000, 1'b0, 1'b0};
    vecs[7] = '{24'h000100, 24'h000003, 24'h005555, 1'b0, 1'b0};
    vecs[8] = '{24'h800300, 24'h800200, 24'h000180, 1'b0, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset out", 32'(out), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    count_done(5, pulses);
    check("no spurious done", 32'(pulses), 32'd0);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d busy after accept", i), 32'(busy), 32'd1);
      wait_done(edges);
      check($sformatf("v%0d latency", i), 32'(edges), 32'd32);
      check($sformatf("v%0d out", i), 32'(out), 32'(vecs[i].exp_out));
      check($sformatf("v%0d div_zero", i), 32'(div_zero), 32'(vecs[i].exp_dz));
      check($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d busy at done", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d done one cycle", i), 32'(done), 32'd0);
      check($sformatf("v%0d out held", i), 32'(out), 32'(vecs[i].exp_out));
    end

    // start at cycle 5 of a division is ignored
    start_op(24'h000600, 24'h000200);
    repeat (4) @(posedge clk);
    #1;
    a = 24'h000100;
    b = 24'h000100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(edges);
    check("ignored start latency", 32'(edges + 5), 32'd32);
    check("ignored start out", 32'(out), 32'h000300);
    count_done(40, pulses);
    check("ignored start no extra done", 32'(pulses), 32'd0);

    // start in the done cycle is accepted; done pulses 33 cycles apart
    start_op(24'h000600, 24'h000200);
    wait_done(edges);
    check("b2b first latency", 32'(edges), 32'd32);
    start_op(24'h000200, 24'h000300);
    a = 24'h123456;
    b = 24'h000001;
    check("b2b busy after accept", 32'(busy), 32'd1);
    check("b2b out held", 32'(out), 32'h000300);
    wait_done(edges);
    check("b2b done spacing", 32'(edges + 1), 32'd33);
    check("b2b second out", 32'(out), 32'(vecs[2].exp_out));

    // reset at cycle 10 aborts
    start_op(24'h7FFFFF, 24'h000001);
    wait_done(edges);
    check("pre-reset overflow", 32'(overflow), 32'd1);
    start_op(24'h000600, 24'h000200);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort out", 32'(out), 32'd0);
    check("abort div_zero", 32'(div_zero), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    count_done(40, pulses);
    check("abort no done", 32'(pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
